// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Handshaked sequencer for the layer pipeline of the neural net. Each layer
//   is launched with a one-hot enable plus a one-cycle strobe. The sequencer
//   moves to the next layer only when the active layer reports completion.
//
//   Optional build macro: LAYER_TIMEOUT_EN
//     defined   - a per-layer watchdog ends the pass on a stalled layer and
//                 sets the sticky timeout flag.
//     undefined - no watchdog. RUN waits indefinitely and timeout is always 0.
//
//   Ports
//     clk          system clock, rising edge
//     rst          synchronous active-high reset
//     start        request a full pass (honoured only when idle)
//     abort        cancel the pass from any state
//     layer_done   per-layer completion pulse; only bit cur_layer is used
//     layer_en     one-hot enable of the active layer
//     layer_start  one-cycle strobe on the first cycle of each layer_en value
//     cur_layer    index of the active layer
//     busy         pass in progress
//     done         one-cycle pulse at the end of a pass
//     timeout      sticky watchdog flag, cleared by rst or an accepted start
//
//   state  | meaning
//   IDLE   | waiting for start
//   LAUNCH | one cycle: reset watchdog, strobe the current layer
//   RUN    | waiting for layer_done[cur_layer] or watchdog expiry
//   FIN    | one cycle: end-of-pass, done pulse
module layer_sequencer #(
  parameter int LAYER_NO   = 4,
  parameter int MAX_CYCLES = 10,
  localparam int IDX_W     = $clog2(LAYER_NO)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [LAYER_NO-1:0] layer_done,
  output logic [LAYER_NO-1:0] layer_en,
  output logic                layer_start,
  output logic [IDX_W-1:0]    cur_layer,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  if (LAYER_NO < 2 || MAX_CYCLES < 2) begin : g_bad_params
    $error("layer_sequencer: LAYER_NO and MAX_CYCLES must both be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FIN} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tmo_pend_q, tmo_pend_d;
  logic [LAYER_NO-1:0]  layer_en_q, layer_en_d;
  logic                 layer_start_q, layer_start_d;
  logic [IDX_W-1:0]     cur_layer_q, cur_layer_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;

  logic hit;
  logic last;
  logic expire;
  logic kill;
  logic accept;

  assign hit    = layer_done[idx_q];
  assign last   = (idx_q == IDX_W'(LAYER_NO - 1));
  assign kill   = abort && (state_q != S_IDLE);
  assign accept = (state_q == S_IDLE) && start && !abort;

`ifdef LAYER_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_CYCLES);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  // Cleared outside RUN so the first RUN cycle sees zero; saturates at the
  // terminal value rather than wrapping.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q != S_RUN) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != CNT_W'(MAX_CYCLES - 1)) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end

  assign expire = (state_q == S_RUN) && (wd_cnt_q == CNT_W'(MAX_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // Next-state logic. Completion is tested before expiry so it wins a tie.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_pend_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LAUNCH;
          idx_d   = '0;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        if (hit) begin
          if (last) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LAUNCH;
          end
        end else if (expire) begin
          tmo_pend_d = 1'b1;
          state_d    = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      tmo_pend_d = 1'b0;
    end
  end

  // Output registers carry the image of the current state, so every output
  // trails the state register by one cycle. The one exception is abort,
  // which clears the outputs on the same edge that returns the FSM to IDLE.
  // The timeout flag travels through tmo_pend so that it rises together with
  // the done pulse.
  always_comb begin
    layer_en_d    = '0;
    layer_start_d = 1'b0;
    cur_layer_d   = '0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    timeout_d     = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) timeout_d = 1'b0;
      end
      S_LAUNCH: begin
        layer_en_d    = LAYER_NO'(1) << idx_q;
        layer_start_d = 1'b1;
        cur_layer_d   = idx_q;
        busy_d        = 1'b1;
      end
      S_RUN: begin
        layer_en_d  = LAYER_NO'(1) << idx_q;
        cur_layer_d = idx_q;
        busy_d      = 1'b1;
      end
      S_FIN: begin
        cur_layer_d = idx_q;
        busy_d      = 1'b1;
        done_d      = 1'b1;
        if (tmo_pend_q) timeout_d = 1'b1;
      end
      default: ;
    endcase
    if (kill) begin
      layer_en_d    = '0;
      layer_start_d = 1'b0;
      cur_layer_d   = '0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      timeout_d     = timeout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      tmo_pend_q    <= 1'b0;
      layer_en_q    <= '0;
      layer_start_q <= 1'b0;
      cur_layer_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tmo_pend_q    <= tmo_pend_d;
      layer_en_q    <= layer_en_d;
      layer_start_q <= layer_start_d;
      cur_layer_q   <= cur_layer_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign layer_en    = layer_en_q;
  assign layer_start = layer_start_q;
  assign cur_layer   = cur_layer_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;

endmodule
